// File: rtl/nf_uart_pkg.sv
// Shared types for the buffered UART transmitter: parity modes, FSM states,
// and the bit-counter width helper.
package nf_uart_pkg;

  typedef enum logic [1:0] {
    NF_PAR_NONE = 2'd0,
    NF_PAR_EVEN = 2'd1,
    NF_PAR_ODD  = 2'd2
  } nf_par_e;

  typedef enum logic [2:0] {
    NF_IDLE,
    NF_START,
    NF_DATA,
    NF_PARITY,
    NF_STOP,
    NF_GAP
  } nf_tx_state_e;

  function automatic int nf_bcnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/nf_fifo_sync.sv
// Synchronous FIFO with level count; a push into a full FIFO is accepted only
// when a pop happens in the same cycle, otherwise it is dropped and flagged.
module nf_fifo_sync #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level,
  output logic              ovf_pulse
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push_ok, pop_ok;

  assign full      = (level == LW'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign ovf_pulse = push && !push_ok;
  assign pop_data  = mem[rd_ptr];

  // Pointers are power-of-2 wide, so plain increment wraps modulo depth.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nf_uart_tx_buf.sv
// Buffered UART transmitter: message FIFO feeding a frame FSM with runtime
// baud divisor, optional parity, 1/2 stop bits and an inter-frame gap.
module nf_uart_tx_buf
  import nf_uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int GAP_W      = 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             tx_en,
  input  logic [DIV_W-1:0]                 cfg_div,
  input  logic [1:0]                       cfg_par,
  input  logic                             cfg_stop2,
  input  logic [GAP_W-1:0]                 cfg_gap,
  input  logic                             wr_en,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             clr_ovf,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
  output logic                             busy,
  output logic                             ovf,
  output logic                             uart_tx
);

  localparam int BCW = nf_bcnt_w(DATA_W);

  nf_tx_state_e      state, state_n;
  logic [DIV_W-1:0]  baud, baud_n, div_l, div_eff;
  logic [BCW-1:0]    bcnt, bcnt_n;
  logic [GAP_W-1:0]  gcnt, gcnt_n, gap_l;
  logic [DATA_W-1:0] shift, shift_n, fifo_data;
  logic              par_en_l, par_bit_l, stop2_l;
  logic              pop, done, bit_end, tx_n, fifo_ovf;

  nf_fifo_sync #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .ovf_pulse (fifo_ovf)
  );

  assign div_eff = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
  assign bit_end = (baud == '0);
  assign busy    = (state != NF_IDLE);

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bcnt_n  = bcnt;
    gcnt_n  = gcnt;
    shift_n = shift;
    pop     = 1'b0;
    done    = 1'b0;
    tx_n    = 1'b1;
    if (state != NF_IDLE) baud_n = bit_end ? div_l - 1'b1 : baud - 1'b1;
    if (state != NF_IDLE && bit_end) begin
      case (state)
        NF_START: begin
          state_n = NF_DATA;
          bcnt_n  = BCW'(DATA_W - 1);
        end
        NF_DATA:
          if (bcnt != '0) begin
            bcnt_n  = bcnt - 1'b1;
            shift_n = shift >> 1;
          end else if (par_en_l) begin
            state_n = NF_PARITY;
          end else begin
            state_n = NF_STOP;
            bcnt_n  = BCW'(stop2_l);
          end
        NF_PARITY: begin
          state_n = NF_STOP;
          bcnt_n  = BCW'(stop2_l);
        end
        NF_STOP:
          if (bcnt != '0) bcnt_n = bcnt - 1'b1;
          else if (gap_l != '0) begin
            state_n = NF_GAP;
            gcnt_n  = gap_l - 1'b1;
          end else done = 1'b1;
        NF_GAP:
          if (gcnt != '0) gcnt_n = gcnt - 1'b1;
          else done = 1'b1;
        default: done = 1'b1;
      endcase
    end
    // End of frame chains straight into the next start: no idle clock between frames.
    if ((state == NF_IDLE || done) && tx_en && !empty) begin
      pop     = 1'b1;
      state_n = NF_START;
      baud_n  = div_eff - 1'b1;
      shift_n = fifo_data;
    end else if (done) begin
      state_n = NF_IDLE;
    end
    case (state_n)
      NF_START:  tx_n = 1'b0;
      NF_DATA:   tx_n = shift_n[0];
      NF_PARITY: tx_n = par_bit_l;
      default:   tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state     <= NF_IDLE;
      baud      <= '0;
      bcnt      <= '0;
      gcnt      <= '0;
      shift     <= '0;
      div_l     <= DIV_W'(1);
      par_en_l  <= 1'b0;
      par_bit_l <= 1'b0;
      stop2_l   <= 1'b0;
      gap_l     <= '0;
      uart_tx   <= 1'b1;
      ovf       <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bcnt    <= bcnt_n;
      gcnt    <= gcnt_n;
      shift   <= shift_n;
      uart_tx <= tx_n;
      if (pop) begin
        div_l     <= div_eff;
        par_en_l  <= (cfg_par == NF_PAR_EVEN) || (cfg_par == NF_PAR_ODD);
        par_bit_l <= (^fifo_data) ^ (cfg_par == NF_PAR_ODD);
        stop2_l   <= cfg_stop2;
        gap_l     <= cfg_gap;
      end
      if (fifo_ovf)     ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nf_uart_tx_buf.sv
// Directed bench for nf_uart_tx_buf: decodes the serial line and compares
// against hand-computed frames, timing and FIFO status.
module tb_nf_uart_tx_buf;
  localparam int DATA_W = 8, FIFO_DEPTH = 16, DIV_W = 16, GAP_W = 8, LW = 5;

  logic              clk = 1'b0, resetn = 1'b1, tx_en = 1'b0;
  logic              cfg_stop2 = 1'b0, wr_en = 1'b0, clr_ovf = 1'b0;
  logic [DIV_W-1:0]  cfg_div = 16'd4;
  logic [1:0]        cfg_par = 2'd0;
  logic [GAP_W-1:0]  cfg_gap = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              full, empty, busy, ovf, uart_tx;
  logic [LW-1:0]     level;
  int                errors = 0, checks = 0, cyc = 0;

  nf_uart_tx_buf #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .resetn(resetn), .tx_en(tx_en), .cfg_div(cfg_div), .cfg_par(cfg_par),
    .cfg_stop2(cfg_stop2), .cfg_gap(cfg_gap), .wr_en(wr_en), .wr_data(wr_data),
    .clr_ovf(clr_ovf), .full(full), .empty(empty), .level(level), .busy(busy),
    .ovf(ovf), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // All tasks start and end just after a falling edge.
  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_start(input int limit, output int steps, output bit ok);
    ok = 1'b0; steps = 0;
    while (!ok && steps < limit) begin
      if (uart_tx === 1'b0) ok = 1'b1;
      else begin @(negedge clk); steps++; end
    end
  endtask

  // Returns at the first clock of the (first) stop bit; bits[nb] is that stop sample.
  task automatic rx_frame(input int div, input int nb, output logic [9:0] bits,
                          output int hs, output int t0, output bit ok);
    bits = '1;
    wait_start(20000, hs, ok);
    t0 = cyc;
    if (ok) for (int i = 0; i <= nb; i++) begin
      repeat (div) @(negedge clk);
      bits[i] = uart_tx;
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin @(negedge clk); n++; end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({uart_tx, busy, ovf, empty, full} !== 5'b10010) begin
      errors++; $display("FAIL reset_flags got=%b exp=10010", {uart_tx, busy, ovf, empty, full});
    end
    checks++;
    if (level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    resetn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte;
    logic [9:0] bits; int hs, t0; bit ok;
    cfg_div = 16'd434; cfg_par = 2'd0; cfg_stop2 = 1'b0; cfg_gap = '0; tx_en = 1'b1;
    wr(8'h48);
    checks++;
    if (uart_tx !== 1'b1 || level !== 5'd1) begin
      errors++; $display("FAIL single_pre tx=%b level=%0d exp tx=1 level=1", uart_tx, level);
    end
    @(negedge clk);
    checks++;
    if (uart_tx !== 1'b0 || busy !== 1'b1 || level !== 5'd0) begin
      errors++; $display("FAIL single_start tx=%b busy=%b level=%0d exp 0 1 0", uart_tx, busy, level);
    end
    rx_frame(434, 8, bits, hs, t0, ok);
    checks++;
    if (!ok || bits[8:0] !== 9'h148) begin
      errors++; $display("FAIL single_data got=%h exp=148 ok=%0d", bits[8:0], ok);
    end
    wait_idle(5000, ok);
    checks++;
    if (!ok || (cyc - t0) != 4340) begin
      errors++; $display("FAIL single_busy_len got=%0d exp=4340", cyc - t0);
    end
  endtask

  task automatic test_message;
    logic [7:0] msg [12];
    int bad_gap = 0, tprev = 0;
    bit ok;
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    cfg_div = 16'd4; cfg_gap = 8'd2; tx_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) wr(msg[i]);
        checks++;
        if (level !== 5'd11) begin errors++; $display("FAIL msg_level_peak got=%0d exp=11", level); end
      end
      begin
        logic [9:0] bits; int hs, t; bit rok;
        for (int j = 0; j < 12; j++) begin
          rx_frame(4, 8, bits, hs, t, rok);
          checks++;
          if (!rok || bits[8:0] !== {1'b1, msg[j]}) begin
            errors++; $display("FAIL msg_data[%0d] got=%h exp=%h", j, bits[8:0], {1'b1, msg[j]});
          end
          if (j > 0 && (t - tprev) != 48) bad_gap++;
          tprev = t;
        end
      end
    join
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL msg_spacing bad_frames=%0d exp=0 (48 clk each)", bad_gap); end
    wait_idle(200, ok);
    cfg_gap = '0;
  endtask

  task automatic test_parity_stop;
    logic [9:0] bits; int hs, t0, t1; bit ok;
    cfg_div = 16'd2; cfg_gap = '0; cfg_stop2 = 1'b0; tx_en = 1'b1;
    cfg_par = 2'd1;
    wr(8'h07);
    rx_frame(2, 9, bits, hs, t0, ok);
    checks++;
    if (!ok || bits !== 10'h307) begin errors++; $display("FAIL par_even got=%h exp=307", bits); end
    wait_idle(100, ok);
    cfg_par = 2'd2;
    wr(8'h07);
    rx_frame(2, 9, bits, hs, t0, ok);
    checks++;
    if (!ok || bits !== 10'h207) begin errors++; $display("FAIL par_odd got=%h exp=207", bits); end
    wait_idle(100, ok);
    cfg_par = 2'd0; cfg_stop2 = 1'b1;
    wr(8'h81); wr(8'h3C);
    rx_frame(2, 8, bits, hs, t0, ok);
    checks++;
    if (!ok || bits[8:0] !== 9'h181) begin errors++; $display("FAIL stop2_data0 got=%h exp=181", bits[8:0]); end
    rx_frame(2, 8, bits, hs, t1, ok);
    checks++;
    if (!ok || bits[8:0] !== 9'h13C) begin errors++; $display("FAIL stop2_data1 got=%h exp=13c", bits[8:0]); end
    checks++;
    if (hs != 4 || (t1 - t0) != 22) begin
      errors++; $display("FAIL stop2_timing high=%0d period=%0d exp 4 22", hs, t1 - t0);
    end
    wait_idle(100, ok);
    cfg_stop2 = 1'b0;
  endtask

  task automatic test_overflow;
    logic [9:0] bits; int hs, t, tprev = 0, bad = 0, lows = 0; bit ok;
    tx_en = 1'b0; cfg_div = '0;
    for (int i = 0; i < 17; i++) wr(8'h10 + 8'(i));
    checks++;
    if ({full, ovf} !== 2'b11 || level !== 5'd16) begin
      errors++; $display("FAIL ovf_status full=%b ovf=%b level=%0d exp 1 1 16", full, ovf, level);
    end
    clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    tx_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_frame(1, 8, bits, hs, t, ok);
      if (!ok || bits[8:0] !== {1'b1, 8'h10 + 8'(i)}) bad++;
      if (i > 0 && (t - tprev) != 10) bad++;
      tprev = t;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ovf_drain bad=%0d exp=0 (0x10..0x1f, 10 clk frames)", bad); end
    wait_idle(50, ok);
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    checks++;
    if (lows != 0 || empty !== 1'b1) begin
      errors++; $display("FAIL ovf_17th_lost low_clks=%0d empty=%b exp 0 1", lows, empty);
    end
  endtask

  task automatic test_full_pop_write;
    logic [9:0] bits; int hs, t, bad = 0; bit ok;
    tx_en = 1'b0; cfg_div = '0;
    for (int i = 0; i < 16; i++) wr(8'h30 + 8'(i));
    tx_en = 1'b1;
    wr(8'hEE);
    checks++;
    if (level !== 5'd16 || ovf !== 1'b0) begin
      errors++; $display("FAIL fullpop_write level=%0d ovf=%b exp 16 0", level, ovf);
    end
    for (int i = 0; i < 16; i++) begin
      rx_frame(1, 8, bits, hs, t, ok);
      if (!ok || bits[8:0] !== {1'b1, 8'h30 + 8'(i)}) bad++;
    end
    rx_frame(1, 8, bits, hs, t, ok);
    checks++;
    if (bad != 0 || !ok || bits[8:0] !== 9'h1EE) begin
      errors++; $display("FAIL fullpop_drain bad=%0d last=%h exp 0 1ee", bad, bits[8:0]);
    end
    wait_idle(50, ok);
  endtask

  task automatic test_txen_drop;
    logic [9:0] bits; int hs, t, act = 0; bit ok;
    cfg_div = 16'd4; tx_en = 1'b1;
    wr(8'hC3); wr(8'h5A);
    fork
      rx_frame(4, 8, bits, hs, t, ok);
      begin repeat (10) @(negedge clk); tx_en = 1'b0; end
    join
    checks++;
    if (!ok || bits[8:0] !== 9'h1C3) begin errors++; $display("FAIL txen_frame got=%h exp=1c3", bits[8:0]); end
    wait_idle(100, ok);
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (uart_tx !== 1'b1 || busy !== 1'b0) act++; end
    checks++;
    if (!ok || act != 0 || level !== 5'd1) begin
      errors++; $display("FAIL txen_hold active_clks=%0d level=%0d exp 0 1", act, level);
    end
    tx_en = 1'b1;
    rx_frame(4, 8, bits, hs, t, ok);
    checks++;
    if (!ok || bits[8:0] !== 9'h15A) begin errors++; $display("FAIL txen_resume got=%h exp=15a", bits[8:0]); end
    wait_idle(100, ok);
  endtask

  task automatic test_async_reset;
    logic [9:0] bits; int hs, t, lows = 0; bit ok;
    cfg_div = 16'd4; tx_en = 1'b1;
    wr(8'h55); wr(8'h66);
    repeat (10) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b0 || level !== 5'd1) begin
      errors++; $display("FAIL areset_pre tx=%b level=%0d exp 0 1", uart_tx, level);
    end
    #2 resetn = 1'b1;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || level !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL areset_now tx=%b busy=%b level=%0d empty=%b exp 1 0 0 1", uart_tx, busy, level, empty);
    end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    wr(8'hA5);
    rx_frame(4, 8, bits, hs, t, ok);
    checks++;
    if (!ok || bits[8:0] !== 9'h1A5) begin errors++; $display("FAIL areset_after got=%h exp=1a5", bits[8:0]); end
    wait_idle(100, ok);
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    checks++;
    if (!ok || lows != 0 || empty !== 1'b1) begin
      errors++; $display("FAIL areset_flushed low_clks=%0d empty=%b exp 0 1", lows, empty);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_message();
    test_parity_stop();
    test_overflow();
    test_full_pop_write();
    test_txen_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog cycles=%0d exp finish earlier", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
